and_reg_stim_chk: RTL and testbench

Self-checking stimulus source and response checker for the registered two-input AND stage. It drives in0/in1 from an 8-bit LFSR and samples that stage's registered output. It compares each sample against an internally pipelined expected value and reports vector count, error count and pass/fail through a start/done handshake. It sits in the rtl_sim harness as the opposite end of the AND stage's interface: it drives the stage's inputs and receives its output.

---
 rtl/and_reg_stim_chk.sv | 121 ++++++++++++
 tb/tb_and_reg_stim_chk.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/and_reg_stim_chk.sv
// LFSR stimulus source and response checker for a registered two-input AND stage.
// Drives in0/in1, compares the stage output two edges later and reports the result of each run.
module and_reg_stim_chk #(
  parameter int         NUM_VECTORS = 16,
  parameter int         CNT_W       = 8,
  parameter logic [7:0] SEED        = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_out,
  output logic             in0,
  output logic             in1,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [15:0]      vec_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 8'h01.
  localparam logic [7:0]       SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [15:0]      NUM_V    = 16'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] ERR_MAX  = '1;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  lfsr;
  logic [15:0] drv_cnt;
  logic        drain_cnt;
  logic        exp_q;
  logic        chk_vld_q;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  assign busy = (state == DRIVE) || (state == DRAIN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (drv_cnt == NUM_V) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // exp_q/chk_vld_q describe the vector the stage registers on the next edge,
  // so they line up with dut_out one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in0       <= 1'b0;
      in1       <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      vec_cnt   <= '0;
      exp_q     <= 1'b0;
      chk_vld_q <= 1'b0;
      lfsr      <= SEED;
      drv_cnt   <= '0;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      exp_q     <= in0 & in1;
      chk_vld_q <= (state == DRIVE);

      if (chk_vld_q) begin
        vec_cnt <= vec_cnt + 16'd1;
        if ((dut_out != exp_q) && (err_cnt != ERR_MAX))
          err_cnt <= err_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            in0     <= SEED_EFF[0];
            in1     <= SEED_EFF[1];
            lfsr    <= lfsr_next(SEED_EFF);
            drv_cnt <= 16'd1;
            err_cnt <= '0;
            vec_cnt <= '0;
            pass    <= 1'b0;
          end
        end
        DRIVE: begin
          if (drv_cnt == NUM_V) begin
            in0       <= 1'b0;
            in1       <= 1'b0;
            drain_cnt <= 1'b0;
          end else begin
            in0     <= lfsr[0];
            in1     <= lfsr[1];
            lfsr    <= lfsr_next(lfsr);
            drv_cnt <= drv_cnt + 16'd1;
          end
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          // The last compare landed on the previous edge, so err_cnt is final here.
          if (drain_cnt) begin
            done <= 1'b1;
            pass <= (err_cnt == '0);
          end
        end
        DONE: begin
          done <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_and_reg_stim_chk.sv
// Bench for and_reg_stim_chk: three configurations driving a bench-side registered AND stage
// with selectable stuck-at faults, checked every cycle against a run-timeline model.
module tb_and_reg_stim_chk;

  logic clk;
  logic rst;
  logic start;
  int   fault;
  bit   chk_en;

  int n_cmp;
  int n_err;

  logic [2:0]       d_in0, d_in1, d_busy, d_done, d_pass;
  logic [2:0]       stage_q;
  logic [2:0]       d_out;
  logic [2:0][15:0] d_err;
  logic [2:0][15:0] d_vec;
  logic [7:0]       err_a;
  logic [2:0]       err_b;
  logic [7:0]       err_c;

  // Per-instance configuration as seen by the model: vectors, saturation limit, effective seed.
  int         nv[3]    = '{16, 16, 1};
  int         cmax[3]  = '{255, 7, 255};
  logic [7:0] seeds[3] = '{8'hA5, 8'hA5, 8'h01};

  logic [7:0] golden[16] = '{8'hA5, 8'h4A, 8'h95, 8'h2A, 8'h54, 8'hA9, 8'h53, 8'hA7,
                             8'h4E, 8'h9D, 8'h3B, 8'h77, 8'hEE, 8'hDD, 8'hBB, 8'h76};

  bit m_run[3];
  int m_k[3];
  int m_err[3];
  int m_vec[3];
  bit m_pass[3], m_in0[3], m_in1[3], m_busy[3], m_done[3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  and_reg_stim_chk #(.NUM_VECTORS(16), .CNT_W(8), .SEED(8'hA5)) u_a (
    .clk(clk), .rst(rst), .start(start), .dut_out(d_out[0]),
    .in0(d_in0[0]), .in1(d_in1[0]), .busy(d_busy[0]), .done(d_done[0]),
    .pass(d_pass[0]), .err_cnt(err_a), .vec_cnt(d_vec[0])
  );

  and_reg_stim_chk #(.NUM_VECTORS(16), .CNT_W(3), .SEED(8'hA5)) u_b (
    .clk(clk), .rst(rst), .start(start), .dut_out(d_out[1]),
    .in0(d_in0[1]), .in1(d_in1[1]), .busy(d_busy[1]), .done(d_done[1]),
    .pass(d_pass[1]), .err_cnt(err_b), .vec_cnt(d_vec[1])
  );

  and_reg_stim_chk #(.NUM_VECTORS(1), .CNT_W(8), .SEED(8'h00)) u_c (
    .clk(clk), .rst(rst), .start(start), .dut_out(d_out[2]),
    .in0(d_in0[2]), .in1(d_in1[2]), .busy(d_busy[2]), .done(d_done[2]),
    .pass(d_pass[2]), .err_cnt(err_c), .vec_cnt(d_vec[2])
  );

  assign d_err[0] = {8'h00, err_a};
  assign d_err[1] = {13'h0000, err_b};
  assign d_err[2] = {8'h00, err_c};

  // Stage under test: registered AND, optionally stuck at 0 (fault 1) or 1 (fault 2).
  always @(posedge clk) stage_q <= d_in0 & d_in1;
  assign d_out = (fault == 1) ? 3'b000 : (fault == 2) ? 3'b111 : stage_q;

  function automatic logic [7:0] lfsr_state(input logic [7:0] s0, input int i);
    logic [7:0] s;
    s = s0;
    for (int t = 0; t < i; t++) s = {s[6:0], ^(s & 8'hB8)};
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s);
    @(negedge clk);
    rst   = r;
    start = s;
  endtask

  // Waits (bounded) from just after the start edge until done of instance 0 is seen.
  task automatic waitDone(output int lat);
    lat = 0;
    while (!d_done[0] && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("done_seen", d_done[0], 1);
  endtask

  // Run timeline model: k counts edges since the accepted start edge.
  always @(posedge clk) begin
    int k, n, i;
    logic [7:0] v;
    bit want, got;
    for (int j = 0; j < 3; j++) begin
      n = nv[j];
      if (rst) begin
        m_run[j] = 0; m_k[j] = 0; m_err[j] = 0; m_vec[j] = 0;
        m_pass[j] = 0; m_in0[j] = 0; m_in1[j] = 0; m_busy[j] = 0; m_done[j] = 0;
      end else if (m_run[j]) begin
        m_k[j]++;
        k = m_k[j];
        if (k >= 2 && k - 2 < n) begin
          i = k - 2;
          v = lfsr_state(seeds[j], i);
          want = v[0] & v[1];
          got = (fault == 1) ? 1'b0 : (fault == 2) ? 1'b1 : want;
          m_vec[j]++;
          if (got != want && m_err[j] < cmax[j]) m_err[j]++;
        end
        v = lfsr_state(seeds[j], k);
        m_in0[j]  = (k < n) ? v[0] : 1'b0;
        m_in1[j]  = (k < n) ? v[1] : 1'b0;
        m_busy[j] = (k <= n + 1);
        m_done[j] = (k == n + 2);
        if (k == n + 2) m_pass[j] = (m_err[j] == 0);
        if (k == n + 3) m_run[j] = 0;
      end else if (start) begin
        v = seeds[j];
        m_run[j] = 1; m_k[j] = 0; m_err[j] = 0; m_vec[j] = 0; m_pass[j] = 0;
        m_in0[j] = v[0]; m_in1[j] = v[1]; m_busy[j] = 1; m_done[j] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int j = 0; j < 3; j++) begin
        checkOutput($sformatf("u%0d_in0", j), d_in0[j], m_in0[j]);
        checkOutput($sformatf("u%0d_in1", j), d_in1[j], m_in1[j]);
        checkOutput($sformatf("u%0d_busy", j), d_busy[j], m_busy[j]);
        checkOutput($sformatf("u%0d_done", j), d_done[j], m_done[j]);
        checkOutput($sformatf("u%0d_pass", j), d_pass[j], m_pass[j]);
        checkOutput($sformatf("u%0d_err_cnt", j), d_err[j], m_err[j]);
        checkOutput($sformatf("u%0d_vec_cnt", j), d_vec[j], m_vec[j]);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int pulses;
    logic [7:0] g;
    n_cmp  = 0;
    n_err  = 0;
    chk_en = 0;
    rst    = 1'b1;
    start  = 1'b0;
    fault  = 0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1;
    $display("[TB] reset released");

    checkOutput("rst_in0", d_in0[0], 0);
    checkOutput("rst_in1", d_in1[0], 0);
    checkOutput("rst_busy", d_busy[0], 0);
    checkOutput("rst_done", d_done[0], 0);
    checkOutput("rst_pass", d_pass[0], 0);
    checkOutput("rst_err", d_err[0], 0);
    checkOutput("rst_vec", d_vec[0], 0);

    // Run 1: correct stage, literal vector sequence and latency.
    $display("[TB] run with correct stage");
    applyStimulus(0, 1);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      g = golden[i];
      checkOutput($sformatf("vec%0d_in0", i), d_in0[0], g[0]);
      checkOutput($sformatf("vec%0d_in1", i), d_in1[0], g[1]);
      checkOutput($sformatf("vec%0d_busy", i), d_busy[0], 1);
      if (i == 0) begin
        checkOutput("c_vec0_in0", d_in0[2], 1);
        checkOutput("c_vec0_in1", d_in1[2], 0);
      end
      if (i == 3) begin
        checkOutput("c_done_s3", d_done[2], 1);
        checkOutput("c_vec_cnt", d_vec[2], 1);
        checkOutput("c_pass", d_pass[2], 1);
      end
      @(negedge clk);
    end
    lat = 16;
    while (!d_done[0] && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("done_latency", lat, 18);
    checkOutput("run1_vec", d_vec[0], 16);
    checkOutput("run1_err", d_err[0], 0);
    checkOutput("run1_pass", d_pass[0], 1);
    repeat (3) @(negedge clk);

    // Stage stuck at 0.
    $display("[TB] run with stage stuck at 0");
    fault = 1;
    applyStimulus(0, 1);
    @(negedge clk);
    start = 1'b0;
    waitDone(lat);
    checkOutput("sa0_err", d_err[0], 5);
    checkOutput("sa0_pass", d_pass[0], 0);
    checkOutput("sa0_vec", d_vec[0], 16);
    checkOutput("sa0_err_b", d_err[1], 5);
    repeat (3) @(negedge clk);

    // Stage stuck at 1: 11 mismatches, 3-bit counter saturates.
    $display("[TB] run with stage stuck at 1");
    fault = 2;
    applyStimulus(0, 1);
    @(negedge clk);
    start = 1'b0;
    waitDone(lat);
    checkOutput("sa1_err_a", d_err[0], 11);
    checkOutput("sa1_err_b", d_err[1], 7);
    checkOutput("sa1_pass_b", d_pass[1], 0);
    checkOutput("sa1_vec_b", d_vec[1], 16);
    repeat (3) @(negedge clk);

    // start held high across a whole run.
    $display("[TB] start held high");
    fault = 0;
    applyStimulus(0, 1);
    @(negedge clk);
    checkOutput("held_err_clr", d_err[0], 0);
    checkOutput("held_vec_clr", d_vec[0], 0);
    waitDone(lat);
    checkOutput("held_lat1", lat, 18);
    @(negedge clk);
    checkOutput("held_idle_busy", d_busy[0], 0);
    @(negedge clk);
    checkOutput("held_rerun_busy", d_busy[0], 1);
    checkOutput("held_rerun_in0", d_in0[0], 1);
    checkOutput("held_rerun_in1", d_in1[0], 0);
    checkOutput("held_rerun_vec", d_vec[0], 0);
    start = 1'b0;
    waitDone(lat);
    checkOutput("held_lat2", lat, 18);
    checkOutput("held_vec2", d_vec[0], 16);
    checkOutput("held_pass2", d_pass[0], 1);
    repeat (3) @(negedge clk);

    // Reset asserted mid-DRIVE.
    $display("[TB] reset during drive");
    fault = 2;
    applyStimulus(0, 1);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("pre_rst_vec", d_vec[0], 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_in0", d_in0[0], 0);
    checkOutput("abort_in1", d_in1[0], 0);
    checkOutput("abort_busy", d_busy[0], 0);
    checkOutput("abort_err", d_err[0], 0);
    checkOutput("abort_vec", d_vec[0], 0);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (d_done[0]) pulses++;
    end
    checkOutput("abort_no_done", pulses, 0);

    fault = 0;
    applyStimulus(0, 1);
    @(negedge clk);
    start = 1'b0;
    waitDone(lat);
    checkOutput("after_abort_lat", lat, 18);
    checkOutput("after_abort_vec", d_vec[0], 16);
    checkOutput("after_abort_pass", d_pass[0], 1);
    repeat (3) @(negedge clk);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
